image_loader: RTL
=================

# image_loader

Upstream feeder for the image sender stage. Accepts 128-bit pixel words (16 × 8-bit grayscale pixels, pixel 0 in bits [7:0]) from a valid/ready host stream and writes them into the image sender's new-image FIFO, honouring its programmable-full back-pressure. After each complete image it issues a one-cycle `image_change` pulse so the sender switches to the new image at the next frame boundary. It also enforces image length and flushes the sender FIFO on abort or length mismatch.

## Interface
Parameters:
- `IMAGE_WIDTH`, 100, image width in pixels
- `IMAGE_HEIGHT`, 100, image height in pixels
- `COUNT_WIDTH`, 16, width of `images_loaded`

Ports:
- `clk_pixel`  in  1  pixel clock; the only clock
- `image_loader_reset`  in  1  synchronous, active-high reset
- `s_data`  in  128  host pixel word
- `s_valid`  in  1  host word valid
- `s_last`  in  1  marks final word of an image
- `s_ready`  out  1  loader accepts word this cycle
- `load_start`  in  1  pulse: arm loading of one image
- `load_abort`  in  1  pulse: cancel current load and flush sender FIFO
- `image_sender_full`  in  1  sender FIFO prog_full
- `image_sender_write`  out  1  sender FIFO write enable
- `image_sender_fifo_din`  out  128  sender FIFO data
- `image_sender_flush`  out  1  sender FIFO flush pulse
- `image_change`  out  1  one-cycle pulse: new image complete in FIFO
- `busy`  out  1  state ≠ IDLE
- `length_error`  out  1  sticky: last load had wrong length
- `images_loaded`  out  COUNT_WIDTH  committed image count

## Operation
- Derived constant: `WORDS_PER_IMAGE = ceil(IMAGE_WIDTH*IMAGE_HEIGHT/16)` (625 at defaults). Word counter: 10 bits at defaults, sized `$clog2(WORDS_PER_IMAGE)`.
- FSM states:
  - IDLE → LOAD on `load_start`. Clears word counter and `length_error`.
  - LOAD → COMMIT on handshake with counter = `WORDS_PER_IMAGE-1` and `s_last`=1.
  - LOAD → FLUSH on handshake with `s_last` ≠ (counter == `WORDS_PER_IMAGE-1`). Sets `length_error`.
  - LOAD → FLUSH on `load_abort`. Does not set `length_error`.
  - COMMIT → IDLE after 1 cycle.
  - FLUSH → IDLE after 1 cycle.
- `s_ready = (state == LOAD) && !image_sender_full && !load_abort`. This is the only combinational output.
- Handshake (`s_valid && s_ready`) registers `s_data` into `image_sender_fifo_din`, sets `image_sender_write` next cycle, and increments the counter.
- A mismatching final word is still written. The subsequent flush discards it.
- COMMIT registers `image_change`=1 for exactly one cycle and increments `images_loaded`. `images_loaded` wraps modulo 2^COUNT_WIDTH.
- FLUSH registers `image_sender_flush`=1 for exactly one cycle.
- `load_abort` in IDLE also enters FLUSH, so software can clear a stale FIFO.
- `load_abort` in COMMIT or FLUSH is ignored.
- `load_start` outside IDLE is ignored.
- `load_start` and `load_abort` together in IDLE: abort wins.
- `image_sender_fifo_din` holds its last value when `image_sender_write`=0.

## Timing
- Reset (synchronous, dominant over all inputs): state IDLE; all outputs 0, including `s_ready`, `image_sender_fifo_din` and counters.
- A reset mid-LOAD does not flush the sender. The sender shares reset.
- Write latency: handshake at cycle t → `image_sender_write`=1 at t+1.
- Commit: final handshake at t; write at t+1 (state COMMIT); `image_change`=1 at t+2; `busy`=0 at t+2.
- `image_change` always follows the final write by one cycle, so the last word is in the FIFO before the sender can sample the change.
- Flush: triggering cycle t → state FLUSH at t+1 → `image_sender_flush`=1 at t+2, IDLE at t+2.
- A write pending at t+1 still occurs; the flush at t+2 removes it.
- Back-pressure: `image_sender_full` gates `s_ready` in the same cycle. The one-word write pipeline relies on prog_full headroom ≥ 2 words.
- Throughput: 1 word/cycle while not full.

## Structure
- Shared package `image_ctrl_pkg`:
  - `BYTE_SIZE`=8, `WORD_BYTES`=16, `WORD_BITS`=128
  - function `words_per_image(w, h)`
  - state enum `image_loader_state_t` {IDLE, LOAD, COMMIT, FLUSH}
- The image sender uses the same package constants.
- Single module, no sub-module. Counter and FSM are inline.

## Test plan
- Full load at defaults: `load_start`, 625 words (`s_last` on word 625), no back-pressure → 625 writes with data in order, one `image_change` 2 cycles after the last handshake, `images_loaded`=1, `length_error`=0.
- Back-pressure: hold `image_sender_full`=1 for 10 cycles mid-image → `s_ready`=0 in the same cycles, zero writes, no words lost, total still 625.
- Early `s_last` on word 300 → 300 writes, `image_sender_flush` pulse, `length_error`=1, no `image_change`, `images_loaded` unchanged. A following good load clears `length_error`.
- Missing `s_last` on word 625 → flush, `length_error`=1.
- `load_abort` at word 100 with `s_valid` high → `s_ready` drops that cycle, one flush pulse, `length_error`=0, IDLE 2 cycles later. `load_start`+`load_abort` together in IDLE → flush only.
- `image_loader_reset` mid-LOAD at word 50 → next cycle all outputs 0, state IDLE. A subsequent load of 625 words commits normally.

Source files
------------

// File: rtl/image_ctrl_pkg.sv
// Shared constants and types for the image loader / image sender pair.
//   BYTE_SIZE, WORD_BYTES, WORD_BITS : pixel and FIFO word geometry
//   words_per_image(w, h)            : FIFO words needed to hold one w x h image
//   image_loader_state_t             : loader FSM states
package image_ctrl_pkg;

  localparam int BYTE_SIZE  = 8;
  localparam int WORD_BYTES = 16;
  localparam int WORD_BITS  = BYTE_SIZE * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    FLUSH  = 2'd3
  } image_loader_state_t;

  // A partially filled last word still costs a whole FIFO word.
  function automatic int words_per_image(input int w, input int h);
    return (w * h + WORD_BYTES - 1) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/image_loader.sv
// Feeds complete images from a valid/ready host stream into the image
// sender's new-image FIFO, then pulses image_change so the sender swaps
// images at its next frame boundary. Wrong-length or aborted loads flush
// the sender FIFO instead.
//
// Ports:
//   clk_pixel, image_loader_reset      : clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready      : host pixel-word stream (pixel 0 in [7:0])
//   load_start, load_abort             : software control pulses
//   image_sender_full                  : sender FIFO prog_full (back-pressure)
//   image_sender_write/_fifo_din       : sender FIFO write port
//   image_sender_flush                 : one-cycle sender FIFO flush
//   image_change                       : one-cycle pulse after a committed image
//   busy, length_error, images_loaded  : status
//
// state  | meaning
// IDLE   | waiting for load_start (or load_abort to flush a stale FIFO)
// LOAD   | accepting host words into the sender FIFO
// COMMIT | final word being written; image_change follows next cycle
// FLUSH  | load cancelled or wrong length; flush pulse follows next cycle
module image_loader
  import image_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 100,
  parameter int IMAGE_HEIGHT = 100,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk_pixel,
  input  logic                   image_loader_reset,
  input  logic [WORD_BITS-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   load_start,
  input  logic                   load_abort,
  input  logic                   image_sender_full,
  output logic                   image_sender_write,
  output logic [WORD_BITS-1:0]   image_sender_fifo_din,
  output logic                   image_sender_flush,
  output logic                   image_change,
  output logic                   busy,
  output logic                   length_error,
  output logic [COUNT_WIDTH-1:0] images_loaded
);

  localparam int WPI   = words_per_image(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int CNT_W = (WPI > 1) ? $clog2(WPI) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPI - 1);

  image_loader_state_t    state_q, state_d;
  logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0]   din_q, din_d;
  logic                   write_q, write_d;
  logic                   flush_q, flush_d;
  logic                   change_q, change_d;
  logic                   busy_q, busy_d;
  logic                   length_error_q, length_error_d;
  logic [COUNT_WIDTH-1:0] images_loaded_q, images_loaded_d;

  logic handshake;
  logic at_last;

  // Abort blocks the handshake in the same cycle so no word slips in
  // while the load is being cancelled.
  assign s_ready   = (state_q == LOAD) && !image_sender_full && !load_abort;
  assign handshake = s_valid && s_ready;
  assign at_last   = (word_cnt_q == LAST_IDX);

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    din_d           = din_q;
    write_d         = handshake;
    flush_d         = (state_q == FLUSH);
    change_d        = (state_q == COMMIT);
    length_error_d  = length_error_q;
    images_loaded_d = images_loaded_q;

    if (state_q == COMMIT) begin
      images_loaded_d = images_loaded_q + COUNT_WIDTH'(1);
    end

    // A mismatching final word is still written; the flush that follows
    // removes it from the sender FIFO.
    if (handshake) begin
      din_d      = s_data;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (load_abort) begin
          state_d = FLUSH;
        end else if (load_start) begin
          state_d        = LOAD;
          word_cnt_d     = '0;
          length_error_d = 1'b0;
        end
      end
      LOAD: begin
        if (load_abort) begin
          state_d = FLUSH;
        end else if (handshake && (s_last || at_last)) begin
          if (s_last && at_last) begin
            state_d = COMMIT;
          end else begin
            state_d        = FLUSH;
            length_error_d = 1'b1;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_pixel) begin
    if (image_loader_reset) begin
      state_q         <= IDLE;
      word_cnt_q      <= '0;
      din_q           <= '0;
      write_q         <= 1'b0;
      flush_q         <= 1'b0;
      change_q        <= 1'b0;
      busy_q          <= 1'b0;
      length_error_q  <= 1'b0;
      images_loaded_q <= '0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      din_q           <= din_d;
      write_q         <= write_d;
      flush_q         <= flush_d;
      change_q        <= change_d;
      busy_q          <= busy_d;
      length_error_q  <= length_error_d;
      images_loaded_q <= images_loaded_d;
    end
  end

  assign image_sender_write    = write_q;
  assign image_sender_fifo_din = din_q;
  assign image_sender_flush    = flush_q;
  assign image_change          = change_q;
  assign busy                  = busy_q;
  assign length_error          = length_error_q;
  assign images_loaded         = images_loaded_q;

endmodule
